cpu_checker_ext: RTL and testbench
==================================

Name: cpu_checker_ext

Overview:
- Parametrised successor to the trace-line format checker. Consumes one ASCII character per clock from the CPU trace stream.
- Recognises register-write lines "^<time>@<pc>: $<grf> <= <data>#" and memory-write lines "^<time>@<pc>: *<addr> <= <data>#".
- Beyond format recognition, it checks field legality (time alignment, PC range/alignment, address range/alignment, GRF index), reports an error code, and counts well-formed lines.
- Sits beside the trace monitor in the CPU testbench infrastructure.

Parameters:
- TIME_DIGITS, 4, maximum decimal digits in time (1..9).
- HEX_DIGITS, 8, exact hex digits in pc, addr and data.
- GRF_DIGITS, 4, maximum decimal digits in the GRF index.
- FREQ_W, 16, width of the freq input.
- PC_MIN, 32'h0000_3000, lowest legal PC (inclusive).
- PC_MAX, 32'h0000_4fff, highest legal PC (inclusive).
- ADDR_MAX, 32'h0000_2fff, highest legal memory address (lowest is 0).
- ALLOW_UPPER, 0, 1 = hex digits A-F are also accepted; 0 = lowercase a-f only.
- CNT_W, 16, width of line_count.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- char  input  8  ASCII character sampled every posedge.
- freq  input  FREQ_W  clock-frequency value; always a power of two >= 2.
- format_type  output  2  00 none, 01 register line, 10 memory line.
- error_code  output  4  bit0 time, bit1 pc, bit2 addr, bit3 grf.
- line_count  output  CNT_W  number of well-formed lines accepted (whether or not they carry errors).

Behaviour:
- Reset (async, active-high): FSM goes to IDLE; all digit counters, accumulators and line_count clear; format_type=00 and error_code=0000 immediately, without waiting for a clock edge.
- FSM states:
  - IDLE
  - CARET
  - TIME
  - AT (pc hex)
  - COLON (spaces)
  - REG_DOL, REG_NUM
  - MEM_STAR, MEM_ADDR
  - PRE_LT (spaces)
  - LT, EQ (spaces)
  - DATA
  - DONE_REG, DONE_MEM
- Field rules:
  - Time: 1..TIME_DIGITS decimal digits, then '@'.
  - pc: exactly HEX_DIGITS hex digits, then ':'.
  - After ':': zero or more spaces, then '$' or '*'.
  - GRF index: 1..GRF_DIGITS decimal digits; addr: exactly HEX_DIGITS hex digits.
  - Then zero or more spaces, '<' and '=' adjacent, zero or more spaces, exactly HEX_DIGITS hex data digits, then '#'.
- Illegal input:
  - '^' in any state moves to CARET and clears all counters and accumulators.
  - Any other unexpected character, or a digit beyond the field limit, moves to IDLE.
- Termination: on '#' with a complete data field, go to DONE_REG or DONE_MEM. From DONE_*, '^' goes to CARET; anything else goes to IDLE.
- Outputs are decoded from state only (Moore):
  - format_type is 01 in DONE_REG, 10 in DONE_MEM, else 00.
  - Valid exactly one cycle, the cycle after the edge that sampled '#'.
- error_code:
  - Zero whenever format_type==00.
  - In DONE_*, it comes from error registers captured on the '#' edge.
- Accumulation:
  - time_acc (32 bits) = time_acc*10 + digit.
  - grf_acc (GRF_DIGITS*4 bits) = grf_acc*10 + digit.
  - pc_acc and addr_acc (32 bits) = shift left 4, OR in the nibble.
  - Uppercase hex maps to the same nibble as lowercase when ALLOW_UPPER=1.
- Error bits:
  - bit0 = (time_acc & ((freq>>1)-1)) != 0.
  - bit1 = pc_acc < PC_MIN, or pc_acc > PC_MAX, or pc_acc[1:0] != 0.
  - bit2 (memory lines only) = addr_acc > ADDR_MAX or addr_acc[1:0] != 0.
  - bit3 (register lines only) = grf_acc >= 32.
  - Bits not applicable to the line type are 0.
- freq is sampled at the '#' edge; changes mid-line have no effect until then.
- line_count increments on the edge that enters DONE_*, and saturates at all ones (no wrap).
- Back-to-back lines: '^' immediately after '#' starts a new line; format_type drops to 00 in the cycle after.
- Leading zeros are legal in time and GRF fields ("$00" = index 0).

Test Plan:
- freq=4, "^10@00003000: $1 <= 0000000f#" -> format_type=01, error_code=0000 for one cycle after '#'; line_count=1.
- freq=4, "^11@00003002: *00003000 <= 12345678#" -> format_type=10, error_code=0111.
- freq=8, "^2@00003004:  $32<=  00000000#" -> format_type=01, error_code=1001 (2 mod 4 != 0, grf 32).
- "^12345@..." (5 time digits), and "^1@0000300:" (7 hex digits) -> format_type stays 00, line_count unchanged. A '^' mid-line then a valid line -> that line is recognised.
- "^4@0000300C: *0000000C <= ABCDEF01#": ALLOW_UPPER=0 -> 00; ALLOW_UPPER=1, freq=2 -> 10, error_code=0000.
- Reset asserted mid-line and between edges -> format_type, error_code and line_count go to 0 immediately. 2^CNT_W valid lines -> line_count holds at all ones.

Source files
------------

// File: rtl/cpu_checker_ext.sv
// Trace-line checker for "^time@pc: $grf <= data#" and "^time@pc: *addr <= data#".
// It validates line syntax, flags illegal field values and counts well-formed lines.
module cpu_checker_ext #(
   parameter int unsigned TIME_DIGITS = 4,
   parameter int unsigned HEX_DIGITS  = 8,
   parameter int unsigned GRF_DIGITS  = 4,
   parameter int unsigned FREQ_W      = 16,
   parameter logic [31:0] PC_MIN      = 32'h0000_3000,
   parameter logic [31:0] PC_MAX      = 32'h0000_4fff,
   parameter logic [31:0] ADDR_MAX    = 32'h0000_2fff,
   parameter bit          ALLOW_UPPER = 1'b0,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        char,
   input  logic [FREQ_W-1:0] freq,
   output logic [1:0]        format_type,
   output logic [3:0]        error_code,
   output logic [CNT_W-1:0]  line_count
);

   localparam int unsigned CW = 5;
   localparam int unsigned GW = GRF_DIGITS * 4;

   localparam logic [7:0] C_CARET = 8'h5e;
   localparam logic [7:0] C_AT    = 8'h40;
   localparam logic [7:0] C_COLON = 8'h3a;
   localparam logic [7:0] C_SPACE = 8'h20;
   localparam logic [7:0] C_DOL   = 8'h24;
   localparam logic [7:0] C_STAR  = 8'h2a;
   localparam logic [7:0] C_LT    = 8'h3c;
   localparam logic [7:0] C_EQ    = 8'h3d;
   localparam logic [7:0] C_HASH  = 8'h23;

   typedef enum logic [3:0] {
      S_IDLE, S_CARET, S_TIME, S_AT, S_COLON,
      S_REG_DOL, S_REG_NUM, S_MEM_STAR, S_MEM_ADDR,
      S_PRE_LT, S_LT, S_EQ, S_DATA, S_DONE_REG, S_DONE_MEM
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [31:0]       time_acc_q;
   logic [31:0]       pc_acc_q;
   logic [31:0]       addr_acc_q;
   logic [GW-1:0]     grf_acc_q;
   logic              is_mem_q;
   logic [3:0]        err_q;
   logic [CNT_W-1:0]  line_count_q;

   logic              is_dec;
   logic              is_hex;
   logic [3:0]        nib;
   logic [3:0]        err_d;
   logic [FREQ_W-1:0] fmask;
   logic [63:0]       fmask_wide;

   // Letters keep their value in the low nibble offset by 9 ('a'/'A' -> 1 + 9 = 10).
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      is_dec = 1'b0;
      is_hex = 1'b0;
      nib    = 4'd0;
      if (char >= 8'h30 && char <= 8'h39) begin
         is_dec = 1'b1;
         is_hex = 1'b1;
         nib    = char[3:0];
      end else if (char >= 8'h61 && char <= 8'h66) begin
         is_hex = 1'b1;
         nib    = char[3:0] + 4'd9;
      end else if (ALLOW_UPPER && char >= 8'h41 && char <= 8'h46) begin
         is_hex = 1'b1;
         nib    = char[3:0] + 4'd9;
      end
   end

   // Error vector as it would be captured if the current char is the closing '#'.
   always_comb begin
      fmask      = (freq >> 1) - FREQ_W'(1);
      fmask_wide = 64'(fmask);
      err_d      = 4'b0000;
      err_d[0]   = |({32'd0, time_acc_q} & fmask_wide);
      err_d[1]   = (pc_acc_q < PC_MIN) || (pc_acc_q > PC_MAX) || (pc_acc_q[1:0] != 2'b00);
      err_d[2]   = is_mem_q && ((addr_acc_q > ADDR_MAX) || (addr_acc_q[1:0] != 2'b00));
      err_d[3]   = !is_mem_q && (32'(grf_acc_q) >= 32'd32);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         time_acc_q   <= '0;
         pc_acc_q     <= '0;
         addr_acc_q   <= '0;
         grf_acc_q    <= '0;
         is_mem_q     <= 1'b0;
         err_q        <= 4'b0000;
         line_count_q <= '0;
      end else if (char == C_CARET) begin
         state_q    <= S_CARET;
         cnt_q      <= '0;
         time_acc_q <= '0;
         pc_acc_q   <= '0;
         addr_acc_q <= '0;
         grf_acc_q  <= '0;
         is_mem_q   <= 1'b0;
      end else begin
         state_q <= S_IDLE;
         case (state_q)
            S_CARET: begin
               if (is_dec) begin
                  state_q    <= S_TIME;
                  time_acc_q <= 32'(nib);
                  cnt_q      <= CW'(1);
               end
            end
            S_TIME: begin
               if (is_dec && cnt_q < CW'(TIME_DIGITS)) begin
                  state_q    <= S_TIME;
                  time_acc_q <= time_acc_q * 32'd10 + 32'(nib);
                  cnt_q      <= cnt_q + CW'(1);
               end else if (char == C_AT) begin
                  state_q <= S_AT;
                  cnt_q   <= '0;
               end
            end
            S_AT: begin
               if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
                  state_q  <= S_AT;
                  pc_acc_q <= {pc_acc_q[27:0], nib};
                  cnt_q    <= cnt_q + CW'(1);
               end else if (char == C_COLON && cnt_q == CW'(HEX_DIGITS)) begin
                  state_q <= S_COLON;
                  cnt_q   <= '0;
               end
            end
            S_COLON: begin
               if (char == C_SPACE) begin
                  state_q <= S_COLON;
               end else if (char == C_DOL) begin
                  state_q  <= S_REG_DOL;
                  is_mem_q <= 1'b0;
               end else if (char == C_STAR) begin
                  state_q  <= S_MEM_STAR;
                  is_mem_q <= 1'b1;
               end
            end
            S_REG_DOL: begin
               if (is_dec) begin
                  state_q   <= S_REG_NUM;
                  grf_acc_q <= GW'(nib);
                  cnt_q     <= CW'(1);
               end
            end
            S_REG_NUM: begin
               if (is_dec && cnt_q < CW'(GRF_DIGITS)) begin
                  state_q   <= S_REG_NUM;
                  grf_acc_q <= grf_acc_q * GW'(10) + GW'(nib);
                  cnt_q     <= cnt_q + CW'(1);
               end else if (char == C_SPACE) begin
                  state_q <= S_PRE_LT;
               end else if (char == C_LT) begin
                  state_q <= S_LT;
               end
            end
            S_MEM_STAR: begin
               if (is_hex) begin
                  state_q    <= S_MEM_ADDR;
                  addr_acc_q <= 32'(nib);
                  cnt_q      <= CW'(1);
               end
            end
            S_MEM_ADDR: begin
               if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
                  state_q    <= S_MEM_ADDR;
                  addr_acc_q <= {addr_acc_q[27:0], nib};
                  cnt_q      <= cnt_q + CW'(1);
               end else if (cnt_q == CW'(HEX_DIGITS) && char == C_SPACE) begin
                  state_q <= S_PRE_LT;
               end else if (cnt_q == CW'(HEX_DIGITS) && char == C_LT) begin
                  state_q <= S_LT;
               end
            end
            S_PRE_LT: begin
               if (char == C_SPACE) state_q <= S_PRE_LT;
               else if (char == C_LT) state_q <= S_LT;
            end
            S_LT: begin
               if (char == C_EQ) state_q <= S_EQ;
            end
            S_EQ: begin
               if (char == C_SPACE) begin
                  state_q <= S_EQ;
               end else if (is_hex) begin
                  state_q <= S_DATA;
                  cnt_q   <= CW'(1);
               end
            end
            S_DATA: begin
               if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
                  state_q <= S_DATA;
                  cnt_q   <= cnt_q + CW'(1);
               end else if (char == C_HASH && cnt_q == CW'(HEX_DIGITS)) begin
                  state_q <= is_mem_q ? S_DONE_MEM : S_DONE_REG;
                  err_q   <= err_d;
                  if (line_count_q != '1) line_count_q <= line_count_q + CW'(0) + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign format_type = (state_q == S_DONE_REG) ? 2'b01 :
                        (state_q == S_DONE_MEM) ? 2'b10 : 2'b00;
   assign error_code  = (format_type != 2'b00) ? err_q : 4'b0000;
   assign line_count  = line_count_q;

endmodule

// File: tb/tb_cpu_checker_ext.sv
// Directed bench for cpu_checker_ext: a default instance and an ALLOW_UPPER=1,
// 3-bit-counter instance share one character stream.
module tb_cpu_checker_ext;

   logic        clk;
   logic        reset;
   logic [7:0]  ch;
   logic [15:0] freq;
   logic [1:0]  ft0, ft1;
   logic [3:0]  ec0, ec1;
   logic [15:0] lc0;
   logic [2:0]  lc1;

   int n_checks = 0;
   int n_errors = 0;

   cpu_checker_ext u_dut (
      .clk         (clk),
      .reset       (reset),
      .char        (ch),
      .freq        (freq),
      .format_type (ft0),
      .error_code  (ec0),
      .line_count  (lc0)
   );

   cpu_checker_ext #(.ALLOW_UPPER(1'b1), .CNT_W(3)) u_up (
      .clk         (clk),
      .reset       (reset),
      .char        (ch),
      .freq        (freq),
      .format_type (ft1),
      .error_code  (ec1),
      .line_count  (lc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_line(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         ch = s[i];
      end
   endtask

   // Result is visible in the cycle after '#' and must be gone one cycle later.
   task automatic expect_line(input string tag, input int ft0e, input int ec0e, input int lc0e,
                              input int ft1e, input int ec1e, input int lc1e);
      @(negedge clk);
      check({tag, "_ft0"}, 32'(ft0), 32'(ft0e));
      check({tag, "_ec0"}, 32'(ec0), 32'(ec0e));
      check({tag, "_lc0"}, 32'(lc0), 32'(lc0e));
      check({tag, "_ft1"}, 32'(ft1), 32'(ft1e));
      check({tag, "_ec1"}, 32'(ec1), 32'(ec1e));
      check({tag, "_lc1"}, 32'(lc1), 32'(lc1e));
      ch = 8'h00;
      @(negedge clk);
      check({tag, "_drop0"}, 32'(ft0), 32'd0);
      check({tag, "_drop1"}, 32'(ft1), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      ch    = 8'h00;
      freq  = 16'd4;
      #3;
      check("rst_ft", 32'(ft0), 32'd0);
      check("rst_ec", 32'(ec0), 32'd0);
      check("rst_lc0", 32'(lc0), 32'd0);
      check("rst_lc1", 32'(lc1), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      send_line("^10@00003000: $1 <= 0000000f#");
      expect_line("reg_ok", 1, 0, 1, 1, 0, 1);
      send_line("^11@00003002: *00003000 <= 12345678#");
      expect_line("mem_err", 2, 7, 2, 2, 7, 2);
      freq = 16'd8;
      send_line("^2@00003004:  $32<=  00000000#");
      expect_line("reg_err", 1, 9, 3, 1, 9, 3);
      send_line("^12345@00003000: $1 <= 00000000#");
      expect_line("time5", 0, 0, 3, 0, 0, 3);
      send_line("^1@0000300: $1 <= 00000000#");
      expect_line("pc7", 0, 0, 3, 0, 0, 3);
      send_line("^1@00^8@00003008: $00 <= 00000000#");
      expect_line("restart", 1, 0, 4, 1, 0, 4);
      freq = 16'd2;
      send_line("^4@0000300C: *0000000C <= ABCDEF01#");
      expect_line("upper", 0, 0, 4, 2, 0, 5);

      send_line("^10@00003000: $1 <= 0000000f#");
      @(negedge clk);
      check("b2b_ft0", 32'(ft0), 32'd1);
      check("b2b_lc0", 32'(lc0), 32'd5);
      check("b2b_lc1", 32'(lc1), 32'd6);
      ch = "^";
      @(negedge clk);
      check("b2b_drop0", 32'(ft0), 32'd0);
      check("b2b_drop1", 32'(ft1), 32'd0);
      send_line("10@00003000: $1 <= 0000000f#");
      expect_line("b2b2", 1, 0, 6, 1, 0, 7);

      send_line("^0@00005000: *00002ffc <= 00000000#");
      expect_line("pc_high", 2, 2, 7, 2, 2, 7);
      send_line("^0@00002ffc: $31 <= 00000000#");
      expect_line("pc_low_sat", 1, 2, 8, 1, 2, 7);

      send_line("^0@00002ffc: $31 <= 00000000#");
      @(negedge clk);
      check("pre_rst_ft0", 32'(ft0), 32'd1);
      check("pre_rst_ec0", 32'(ec0), 32'd2);
      #2 reset = 1'b1;
      #1;
      check("rst_done_ft0", 32'(ft0), 32'd0);
      check("rst_done_ec0", 32'(ec0), 32'd0);
      check("rst_done_lc0", 32'(lc0), 32'd0);
      check("rst_done_ft1", 32'(ft1), 32'd0);
      check("rst_done_lc1", 32'(lc1), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      send_line("^10@00003000: $1 <= 0000000f#");
      expect_line("relearn", 1, 0, 1, 1, 0, 1);
      send_line("^3@00003");
      #2 reset = 1'b1;
      #1;
      check("rst_mid_lc0", 32'(lc0), 32'd0);
      check("rst_mid_lc1", 32'(lc1), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send_line("000: $5 <= 00000000#");
      expect_line("mid_tail", 0, 0, 0, 0, 0, 0);
      send_line("^6@00003010: $5 <= 00000000#");
      expect_line("after_rst", 1, 0, 1, 1, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
